// File: rtl/simd_lane_accum.sv
// Packed SIMD lane accumulator: sums frames of BEATS 48-bit words as
// four 12-bit or two 24-bit independent lanes, with per-lane sticky
// carry/borrow flags, and presents each finished frame on valid/ready.
module simd_lane_accum #(
    parameter int unsigned BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic [3:0]  out_carry
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DATA_W = 48;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [3:0]          r_flags;
    logic                r_mode_q;
    logic [DATA_W-1:0]   r_out_data;
    logic [3:0]          r_out_carry;

    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic                w_mode;
    logic [DATA_W-1:0]   w_base;
    logic [12:0]         w_r12 [4];
    logic [24:0]         w_r24 [2];
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [3:0]          w_flags_beat;
    logic [3:0]          w_flags_nxt;

    // Handshake decode; in_ready depends only on the state register.
    assign out_valid = (r_state == S_HOLD);
    assign in_ready  = ~out_valid;
    assign out_data  = r_out_data;
    assign out_carry = r_out_carry;

    assign w_accept = in_valid & in_ready & ~clear;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == CNT_W'(BEATS - 1));
    assign w_mode   = w_first ? mode : r_mode_q;
    assign w_base   = w_first ? '0 : r_acc;

    // 12-bit lanes: the extra MSB is the carry-out (add) or borrow (sub).
    for (genvar g = 0; g < 4; g++) begin : g_lane12
        assign w_r12[g] = in_op
            ? ({1'b0, w_base[12*g +: 12]} - {1'b0, in_data[12*g +: 12]})
            : ({1'b0, w_base[12*g +: 12]} + {1'b0, in_data[12*g +: 12]});
    end

    // 24-bit lanes, same carry/borrow extraction.
    for (genvar g = 0; g < 2; g++) begin : g_lane24
        assign w_r24[g] = in_op
            ? ({1'b0, w_base[24*g +: 24]} - {1'b0, in_data[24*g +: 24]})
            : ({1'b0, w_base[24*g +: 24]} + {1'b0, in_data[24*g +: 24]});
    end

    // Select the lane split and pack the per-lane flags.
    always_comb begin
        w_acc_nxt    = '0;
        w_flags_beat = '0;
        if (w_mode) begin
            w_acc_nxt    = {w_r24[1][23:0], w_r24[0][23:0]};
            w_flags_beat = {w_r24[1][24], 1'b0, w_r24[0][24], 1'b0};
        end else begin
            w_acc_nxt    = {w_r12[3][11:0], w_r12[2][11:0], w_r12[1][11:0], w_r12[0][11:0]};
            w_flags_beat = {w_r12[3][12], w_r12[2][12], w_r12[1][12], w_r12[0][12]};
        end
        w_flags_nxt = w_first ? w_flags_beat : (r_flags | w_flags_beat);
    end

    // Frame FSM, accumulator and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_flags     <= '0;
            r_mode_q    <= 1'b0;
            r_out_data  <= '0;
            r_out_carry <= '0;
        end else if (clear) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_nxt;
                        r_flags <= w_flags_nxt;
                        if (w_first) begin
                            r_mode_q <= mode;
                        end
                        if (w_last) begin
                            r_cnt       <= '0;
                            r_state     <= S_HOLD;
                            r_out_data  <= w_acc_nxt;
                            r_out_carry <= w_flags_nxt;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_ACCUM;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

endmodule
